// File: rtl/press_encoder_pkg.sv
// Shared definitions for the press encoder: FSM state encodings, default
// press/gap durations and the parameter legality rules checked at elaboration.
package press_enc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DEF_SHORT_CYCLES = 2;
    localparam int DEF_LONG_CYCLES  = 5;
    localparam int DEF_GAP_CYCLES   = 3;
    localparam int DEF_CNT_W        = 8;

    // The duration counter must be able to hold the larger of the long
    // press length and the gap length.
    function automatic bit cnt_w_fits(input int cnt_w, input int long_cycles,
                                      input int gap_cycles);
        longint max_v;
        max_v = (long_cycles > gap_cycles) ? longint'(long_cycles) : longint'(gap_cycles);
        return (cnt_w >= 1) && (cnt_w <= 62) && (max_v < (longint'(1) << cnt_w));
    endfunction

    // All parameter constraints in one place.
    function automatic bit params_legal(input int short_cycles, input int long_cycles,
                                        input int gap_cycles, input int cnt_w);
        return (short_cycles >= 1) && (long_cycles > short_cycles) &&
               (gap_cycles >= 1) && cnt_w_fits(cnt_w, long_cycles, gap_cycles);
    endfunction

endpackage

// File: rtl/press_encoder_if.sv
// Request/response bundle between a press-issuing controller and the press
// encoder.
//   req_valid, req_long : controller -> encoder, press request and its type
//   req_ready           : encoder -> controller, request can be accepted
//   inc, busy, done     : encoder -> controller, button level and status
//   abort               : controller -> encoder, only when PRESS_ENCODER_ABORT_EN
//                         is defined
interface press_encoder_if;
    logic req_valid;
    logic req_long;
    logic req_ready;
    logic inc;
    logic busy;
    logic done;
`ifdef PRESS_ENCODER_ABORT_EN
    logic abort;

    modport master (output req_valid, req_long, abort,
                    input  req_ready, inc, busy, done);
    modport slave  (input  req_valid, req_long, abort,
                    output req_ready, inc, busy, done);
`else
    modport master (output req_valid, req_long,
                    input  req_ready, inc, busy, done);
    modport slave  (input  req_valid, req_long,
                    output req_ready, inc, busy, done);
`endif
endinterface

// File: rtl/press_encoder_tick_down_counter.sv
// tick_down_counter: CNT_W-bit loadable down-counter with a zero flag.
// Load has priority over decrement; decrement saturates at zero so the
// count never wraps.
//   clk, rst  : clock and synchronous active-high reset (count -> 0)
//   load      : load load_val on the next edge
//   load_val  : value to load
//   dec       : decrement on the next edge (ignored at zero)
//   zero      : count is zero
module tick_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Count register: reset, load, saturating decrement or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/press_encoder.sv
// press_encoder: emits a short or long "inc" button press on request,
// followed by a mandatory release gap, then pulses done.
// With acceptance at the edge closing cycle 0 and press length N, gap G:
// inc=1 in cycles 1..N, inc=0 in N+1..N+G, done=1 and ready again in N+G+1.
//   clk_1Hz : sole clock
//   rst     : synchronous active-high reset
//   bus     : press_encoder_if slave (req_valid, req_long, req_ready, inc,
//             busy, done, and abort when PRESS_ENCODER_ABORT_EN is defined)
// Optional feature macro: PRESS_ENCODER_ABORT_EN -- abort in PRESS cuts the
// press short and starts a full-length gap.
module press_encoder
    import press_enc_pkg::*;
#(
    parameter int SHORT_CYCLES = DEF_SHORT_CYCLES,
    parameter int LONG_CYCLES  = DEF_LONG_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic           clk_1Hz,
    input  logic           rst,
    press_encoder_if.slave bus
);

    // Refuse to build with an inconsistent parameter set.
    if (!params_legal(SHORT_CYCLES, LONG_CYCLES, GAP_CYCLES, CNT_W)) begin : g_param_check
        $error("press_encoder: illegal SHORT/LONG/GAP_CYCLES or CNT_W");
    end

    // Counter reload values: a phase of D cycles counts D-1 down to 0.
    localparam logic [CNT_W-1:0] SHORT_M1 = CNT_W'(SHORT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_M1  = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(GAP_CYCLES - 1);

    state_t           state_r;
    state_t           state_s;
    logic             load_s;
    logic [CNT_W-1:0] load_val_s;
    logic             dec_s;
    logic             done_s;
    logic             zero_s;
    logic             abort_s;
    logic             inc_r;
    logic             busy_r;
    logic             done_r;
    logic             req_ready_r;

`ifdef PRESS_ENCODER_ABORT_EN
    assign abort_s = bus.abort;
`else
    assign abort_s = 1'b0;
`endif

    tick_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk_1Hz),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .dec      (dec_s),
        .zero     (zero_s)
    );

    // Next-state and counter control for the IDLE -> PRESS -> GAP sequence.
    always_comb begin
        state_s    = state_r;
        load_s     = 1'b0;
        load_val_s = {CNT_W{1'b0}};
        dec_s      = 1'b0;
        done_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // req_long is only looked at here, at the accepting edge.
                if (bus.req_valid && req_ready_r) begin
                    load_s     = 1'b1;
                    load_val_s = bus.req_long ? LONG_M1 : SHORT_M1;
                    state_s    = ST_PRESS;
                end else begin
                    state_s    = ST_IDLE;
                end
            end
            ST_PRESS: begin
                // An abort enters the gap exactly as a natural press end does.
                if (abort_s || zero_s) begin
                    load_s     = 1'b1;
                    load_val_s = GAP_M1;
                    state_s    = ST_GAP;
                end else begin
                    dec_s      = 1'b1;
                end
            end
            ST_GAP: begin
                if (zero_s) begin
                    done_s     = 1'b1;
                    state_s    = ST_IDLE;
                end else begin
                    dec_s      = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; outputs decode the next state so they
    // line up with the state they describe.
    always_ff @(posedge clk_1Hz) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            inc_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            req_ready_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            inc_r       <= (state_s == ST_PRESS);
            busy_r      <= (state_s != ST_IDLE);
            done_r      <= done_s;
            req_ready_r <= (state_s == ST_IDLE);
        end
    end

    assign bus.inc       = inc_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.req_ready = req_ready_r;

endmodule

// File: tb/tb_press_encoder.sv
// Scoreboard bench for press_encoder with default parameters
// (short=2, long=5, gap=3). Stimulus pushes the expected press/gap lengths
// and accept time; a monitor measures inc/busy and checks them on each done.
module tb_press_encoder;

    typedef struct {
        int     high;
        int     gap;
        longint t_acc;
    } exp_t;

    logic   clk_1Hz;
    logic   rst;
    exp_t   exp_q[$];
    int     checks;
    int     failures;
    int     high_cnt;
    int     gap_cnt;

    press_encoder_if bus ();

    press_encoder dut (
        .clk_1Hz (clk_1Hz),
        .rst     (rst),
        .bus     (bus)
    );

    initial clk_1Hz = 1'b0;
    always #5 clk_1Hz = ~clk_1Hz;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: measure inc-high and gap lengths, compare on every done.
    always @(negedge clk_1Hz) begin
        exp_t   e;
        longint k;
        if (rst) begin
            high_cnt = 0;
            gap_cnt  = 0;
        end else begin
            if (bus.inc) high_cnt++;
            else if (bus.busy) gap_cnt++;
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    k = ($time - e.t_acc - 5) / 10 + 1;
                    check("press_len", high_cnt, e.high);
                    check("gap_len", gap_cnt, e.gap);
                    check("done_cycle", k, e.high + e.gap + 1);
                    check("ready_at_done", bus.req_ready, 1);
                    check("busy_at_done", bus.busy, 0);
                end
                high_cnt = 0;
                gap_cnt  = 0;
            end
        end
    end

    // Wait (bounded) at a falling edge until the encoder is ready.
    task automatic wait_ready();
        int w;
        w = 0;
        @(negedge clk_1Hz);
        while (!bus.req_ready && w < 40) begin
            @(negedge clk_1Hz);
            w++;
        end
        if (!bus.req_ready) check("ready_timeout", 0, 1);
    endtask

    // Issue one press; the expectation is queued before the accepting edge.
    task automatic issue(input bit lng, input int high_exp, input int gap_exp,
                         output longint t_acc);
        wait_ready();
        t_acc = $time + 5;
        exp_q.push_back('{high_exp, gap_exp, t_acc});
        bus.req_valid = 1'b1;
        bus.req_long  = lng;
        @(posedge clk_1Hz);
        #1;
        bus.req_valid = 1'b0;
        bus.req_long  = 1'b0;
    endtask

    // Bounded wait for the scoreboard to drain.
    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 40) begin
            @(negedge clk_1Hz);
            w++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        longint t0;
        int     dones;
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_long  = 1'b0;
`ifdef PRESS_ENCODER_ABORT_EN
        bus.abort     = 1'b0;
`endif
        // Reset state.
        repeat (2) @(posedge clk_1Hz);
        @(negedge clk_1Hz);
        check("rst_inc", bus.inc, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ready", bus.req_ready, 1);
        rst = 1'b0;

        // Short then long press.
        issue(1'b0, 2, 3, t0);
        drain();
        issue(1'b1, 5, 3, t0);
        drain();

        // Back-to-back: req_valid held, req_long toggled during the first
        // press; second accept must land exactly 6 cycles after the first.
        wait_ready();
        t0 = $time + 5;
        exp_q.push_back('{2, 3, t0});
        exp_q.push_back('{5, 3, t0 + 60});
        bus.req_valid = 1'b1;
        bus.req_long  = 1'b0;
        @(posedge clk_1Hz);
        #1;
        bus.req_long  = 1'b1;
        repeat (6) @(posedge clk_1Hz);
        #1;
        bus.req_valid = 1'b0;
        bus.req_long  = 1'b0;
        drain();

        // Reset during cycle 3 of a long press: idle at cycle 4, no done.
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_long  = 1'b1;
        @(posedge clk_1Hz);
        #1;
        bus.req_valid = 1'b0;
        bus.req_long  = 1'b0;
        repeat (2) @(posedge clk_1Hz);
        #1;
        rst = 1'b1;
        @(posedge clk_1Hz);
        #1;
        rst = 1'b0;
        @(negedge clk_1Hz);
        check("midrst_inc", bus.inc, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_ready", bus.req_ready, 1);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done) dones++;
            @(negedge clk_1Hz);
        end
        check("midrst_no_done", dones, 0);

`ifdef PRESS_ENCODER_ABORT_EN
        // Abort in cycle 2 of a long press: 2 high cycles, full gap.
        issue(1'b1, 2, 3, t0);
        @(posedge clk_1Hz);
        #1;
        bus.abort = 1'b1;
        @(posedge clk_1Hz);
        #1;
        bus.abort = 1'b0;
        drain();
`endif

        // One more short press after everything else.
        issue(1'b0, 2, 3, t0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
